// File: rtl/rx_cmd_decoder_pkg.sv
// uart_cmd_pkg: opcodes, FSM state type and ALU operand addresses shared
// by the command decoder, its frame timer and the bench.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file slots that receive the two ALU operands.
    localparam int ALU_A_ADDR = 0;
    localparam int ALU_B_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_WAIT_RESP
    } state_e;

    // True while a frame is partially received and the gap timer runs.
    function automatic logic in_frame(state_e s);
        return (s != ST_IDLE) && (s != ST_WAIT_RESP);
    endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// rx_cmd_decoder_if: receiver-side inputs and request-side outputs of the
// command decoder. slave = decoder side, master = receiver/downstream side.
interface rx_cmd_decoder_if #(
    parameter int ADDR_W = 4
) ();

    // From the UART receiver and the response path.
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              par_err;
    logic              stp_err;
    logic              resp_done;

    // Requests towards register file and ALU.
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic              alu_en;
    logic [3:0]        alu_fun;
    logic              alu_gate_en;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  par_err,
        input  stp_err,
        input  resp_done,
        output rf_wr_en,
        output rf_rd_en,
        output rf_addr,
        output rf_wr_data,
        output alu_en,
        output alu_fun,
        output alu_gate_en,
        output busy,
        output frame_err
    );

    modport master (
        output rx_data,
        output rx_valid,
        output par_err,
        output stp_err,
        output resp_done,
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_addr,
        input  rf_wr_data,
        input  alu_en,
        input  alu_fun,
        input  alu_gate_en,
        input  busy,
        input  frame_err
    );

endinterface

// File: rtl/rx_frame_timer.sv
// rx_frame_timer: inter-byte gap counter. Ports: clk_i, rst_i (async high),
// clr_i (restart), en_i (count), expire_o (count reached TIMEOUT_CYC-1).
module rx_frame_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at LAST so a stuck enable never wraps into a false restart.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: assembles UART bytes into write/read/ALU command frames.
// Ports: CLK, RST (async high), bus (slave modport of rx_cmd_decoder_if).
module rx_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int ADDR_W      = 4
) (
    input  logic            CLK,
    input  logic            RST,
    rx_cmd_decoder_if.slave bus
);

    state_e state_q;
    state_e state_d;

    logic              rf_wr_en_q;
    logic              rf_wr_en_d;
    logic              rf_rd_en_q;
    logic              rf_rd_en_d;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [7:0]        rf_wr_data_q;
    logic [7:0]        rf_wr_data_d;
    logic              alu_en_q;
    logic              alu_en_d;
    logic [3:0]        alu_fun_q;
    logic [3:0]        alu_fun_d;
    logic              gate_q;
    logic              gate_d;
    logic              busy_q;
    logic              busy_d;
    logic              ferr_q;
    logic              ferr_d;

    logic rx_err;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_exp;

    assign rx_err = bus.par_err | bus.stp_err;

    // Any accepted byte, error or state move restarts the gap window.
    assign tmr_clr = bus.rx_valid | rx_err | (state_d != state_q);
    assign tmr_en  = in_frame(state_q);

    rx_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_exp)
    );

    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        ferr_d       = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        gate_d       = gate_q;

        if (state_q == ST_WAIT_RESP) begin
            // Response pending: errors and stray bytes are reported only.
            if (rx_err || bus.rx_valid) begin
                ferr_d = 1'b1;
            end
            if (bus.resp_done) begin
                state_d = ST_IDLE;
                gate_d  = 1'b0;
            end
        end else if (rx_err) begin
            // Error beats a byte arriving in the same cycle.
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    case (bus.rx_data)
                        CMD_WR:      state_d = ST_WR_ADDR;
                        CMD_RD:      state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_ALU_A;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN;
                        default:     ferr_d  = 1'b1;
                    endcase
                end
                ST_WR_ADDR: begin
                    rf_addr_d = bus.rx_data[ADDR_W-1:0];
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    rf_wr_data_d = bus.rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    rf_addr_d  = bus.rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_WAIT_RESP;
                end
                ST_ALU_A: begin
                    rf_addr_d    = ADDR_W'(ALU_A_ADDR);
                    rf_wr_data_d = bus.rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_ALU_B;
                end
                ST_ALU_B: begin
                    rf_addr_d    = ADDR_W'(ALU_B_ADDR);
                    rf_wr_data_d = bus.rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    alu_fun_d = bus.rx_data[3:0];
                    alu_en_d  = 1'b1;
                    gate_d    = 1'b1;
                    state_d   = ST_WAIT_RESP;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmr_exp) begin
            // Frame stalled mid-way: drop it without issuing anything.
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            gate_q       <= 1'b0;
            busy_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            gate_q       <= gate_d;
            busy_q       <= busy_d;
            ferr_q       <= ferr_d;
        end
    end

    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_rd_en    = rf_rd_en_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_fun     = alu_fun_q;
    assign bus.alu_gate_en = gate_q;
    assign bus.busy        = busy_q;
    assign bus.frame_err   = ferr_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb_rx_cmd_decoder: drives byte frames into rx_cmd_decoder and compares
// the observed request/error stream with a frame-level reference model.
module tb_rx_cmd_decoder;
    import uart_cmd_pkg::*;

    localparam int TO = 16;
    localparam int AW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    rx_cmd_decoder_if #(.ADDR_W(AW)) bus ();

    rx_cmd_decoder #(
        .TIMEOUT_CYC (TO),
        .ADDR_W      (AW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // k: 0 write, 1 read, 2 alu start, 3 frame error
    typedef struct {
        int k;
        int a;
        int d;
        int t;
    } ev_t;

    ev_t log_q[$];
    ev_t exp_q[$];

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.rf_wr_en)
                log_q.push_back('{k: 0, a: int'(bus.rf_addr), d: int'(bus.rf_wr_data), t: cyc});
            if (bus.rf_rd_en)
                log_q.push_back('{k: 1, a: int'(bus.rf_addr), d: 0, t: cyc});
            if (bus.alu_en)
                log_q.push_back('{k: 2, a: int'(bus.alu_fun), d: 0, t: cyc});
            if (bus.frame_err)
                log_q.push_back('{k: 3, a: 0, d: 0, t: cyc});
        end
    end

    function automatic string fmt(ev_t q[$]);
        string s;
        string n;
        s = "";
        foreach (q[i]) begin
            case (q[i].k)
                0: n = "wr";
                1: n = "rd";
                2: n = "alu";
                default: n = "err";
            endcase
            s = {s, $sformatf("%s:%0h:%0h ", n, q[i].a, q[i].d)};
        end
        return s;
    endfunction

    // Reference: what one complete frame (or lone bad opcode) must produce.
    function automatic void model_frame(input logic [7:0] b[$]);
        int m;
        m = (1 << AW) - 1;
        case (b[0])
            8'hAA: exp_q.push_back('{k: 0, a: int'(b[1]) & m, d: int'(b[2]), t: 0});
            8'hBB: exp_q.push_back('{k: 1, a: int'(b[1]) & m, d: 0, t: 0});
            8'hCC: begin
                exp_q.push_back('{k: 0, a: 0, d: int'(b[1]), t: 0});
                exp_q.push_back('{k: 0, a: 1, d: int'(b[2]), t: 0});
                exp_q.push_back('{k: 2, a: int'(b[3]) & 15, d: 0, t: 0});
            end
            8'hDD: exp_q.push_back('{k: 2, a: int'(b[1]) & 15, d: 0, t: 0});
            default: exp_q.push_back('{k: 3, a: 0, d: 0, t: 0});
        endcase
    endfunction

    function automatic void push_err();
        exp_q.push_back('{k: 3, a: 0, d: 0, t: 0});
    endfunction

    task automatic clear_logs();
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge CLK);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] b[$], input int maxgap);
        foreach (b[i]) begin
            send_byte(b[i]);
            if (i != b.size() - 1) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic resp_pulse();
        bus.resp_done = 1'b1;
        @(negedge CLK);
        bus.resp_done = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b ferr=%b want 0 0", bus.busy, bus.frame_err);
        end
        checks++;
        if (bus.rf_wr_en !== 1'b0 || bus.rf_rd_en !== 1'b0 || bus.alu_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: wr=%b rd=%b alu=%b want 0 0 0",
                     bus.rf_wr_en, bus.rf_rd_en, bus.alu_en);
        end
        checks++;
        if (bus.rf_addr !== 4'd0 || bus.rf_wr_data !== 8'd0 || bus.alu_fun !== 4'd0
            || bus.alu_gate_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: addr=%h data=%h fun=%h gate=%b want all 0",
                     bus.rf_addr, bus.rf_wr_data, bus.alu_fun, bus.alu_gate_en);
        end
        RST = 1'b0;
        idle(2);
        checks++;
        if (bus.busy !== 1'b0 || log_q.size() != 0) begin
            failures++;
            $display("FAIL reset_release: busy=%b events=%0d want 0 0", bus.busy, log_q.size());
        end
    endtask

    task automatic test_write();
        logic [7:0] b[$];
        clear_logs();
        b = '{8'hAA, 8'h05, 8'h3C};
        model_frame(b);
        send_frame(b, 0);
        idle(2);
        checks++;
        if (fmt(log_q) != fmt(exp_q)) begin
            failures++;
            $display("FAIL write_events: got '%s' want '%s'", fmt(log_q), fmt(exp_q));
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.rf_addr !== 4'd5 || bus.rf_wr_data !== 8'h3C) begin
            failures++;
            $display("FAIL write_hold: busy=%b addr=%h data=%h want 0 5 3c",
                     bus.busy, bus.rf_addr, bus.rf_wr_data);
        end
    endtask

    task automatic test_read();
        logic [7:0] b[$];
        clear_logs();
        b = '{8'hBB, 8'h07};
        model_frame(b);
        send_frame(b, 2);
        idle(2);
        checks++;
        if (fmt(log_q) != fmt(exp_q)) begin
            failures++;
            $display("FAIL read_events: got '%s' want '%s'", fmt(log_q), fmt(exp_q));
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL read_busy_wait: busy=%b want 1", bus.busy);
        end
        send_byte(8'h11);
        push_err();
        idle(2);
        checks++;
        if (fmt(log_q) != fmt(exp_q) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL read_stray_byte: got '%s' busy=%b want '%s' busy=1",
                     fmt(log_q), bus.busy, fmt(exp_q));
        end
        resp_pulse();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL read_resp_done: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_alu();
        logic [7:0] b[$];
        clear_logs();
        b = '{8'hCC, 8'h12, 8'h34, 8'h02};
        model_frame(b);
        send_frame(b, 0);
        checks++;
        if (bus.alu_gate_en !== 1'b1 || bus.alu_en !== 1'b1) begin
            failures++;
            $display("FAIL alu_gate_rise: gate=%b alu_en=%b want 1 1", bus.alu_gate_en, bus.alu_en);
        end
        idle(3);
        bus.resp_done = 1'b1;
        checks++;
        if (bus.alu_gate_en !== 1'b1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL alu_gate_hold: gate=%b busy=%b want 1 1", bus.alu_gate_en, bus.busy);
        end
        @(negedge CLK);
        bus.resp_done = 1'b0;
        checks++;
        if (bus.alu_gate_en !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL alu_gate_fall: gate=%b busy=%b want 0 0", bus.alu_gate_en, bus.busy);
        end
        checks++;
        if (fmt(log_q) != fmt(exp_q)) begin
            failures++;
            $display("FAIL alu_op_events: got '%s' want '%s'", fmt(log_q), fmt(exp_q));
        end
        clear_logs();
        b = '{8'hDD, 8'h08};
        model_frame(b);
        send_frame(b, 1);
        idle(1);
        resp_pulse();
        idle(1);
        checks++;
        if (fmt(log_q) != fmt(exp_q) || bus.alu_fun !== 4'h8) begin
            failures++;
            $display("FAIL alu_nop_events: got '%s' fun=%h want '%s' fun=8",
                     fmt(log_q), bus.alu_fun, fmt(exp_q));
        end
    endtask

    task automatic test_err_abort();
        logic [7:0] b[$];
        clear_logs();
        send_byte(8'hAA);
        send_byte(8'h05);
        bus.par_err = 1'b1;
        @(negedge CLK);
        bus.par_err = 1'b0;
        push_err();
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL parerr_idle: busy=%b want 0", bus.busy);
        end
        // Error coinciding with a data byte: byte must be discarded.
        send_byte(8'hAA);
        bus.stp_err  = 1'b1;
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        @(negedge CLK);
        bus.stp_err  = 1'b0;
        bus.rx_valid = 1'b0;
        push_err();
        idle(1);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stperr_same_cycle: busy=%b want 0", bus.busy);
        end
        b = '{8'hAA, 8'h01, 8'hFF};
        model_frame(b);
        send_frame(b, 1);
        idle(2);
        checks++;
        if (fmt(log_q) != fmt(exp_q)) begin
            failures++;
            $display("FAIL err_recover_events: got '%s' want '%s'", fmt(log_q), fmt(exp_q));
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[$];
        int c0;
        clear_logs();
        send_byte(8'hAA);
        c0 = cyc;
        idle(TO + 3);
        checks++;
        if (log_q.size() != 1 || log_q[0].k != 3) begin
            failures++;
            $display("FAIL timeout_event: got '%s' want 'err:0:0 '", fmt(log_q));
        end else begin
            checks++;
            if (log_q[0].t != c0 + TO) begin
                failures++;
                $display("FAIL timeout_cycle: at +%0d want +%0d", log_q[0].t - c0, TO);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: busy=%b want 0", bus.busy);
        end
        clear_logs();
        b = '{8'h55};
        model_frame(b);
        send_frame(b, 0);
        idle(1);
        checks++;
        if (fmt(log_q) != fmt(exp_q) || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_opcode: got '%s' busy=%b want '%s' busy=0",
                     fmt(log_q), bus.busy, fmt(exp_q));
        end
        // No timeout while waiting for a response.
        clear_logs();
        b = '{8'hBB, 8'h03};
        model_frame(b);
        send_frame(b, 0);
        idle(TO + 5);
        checks++;
        if (fmt(log_q) != fmt(exp_q) || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_no_timeout: got '%s' busy=%b want '%s' busy=1",
                     fmt(log_q), bus.busy, fmt(exp_q));
        end
        resp_pulse();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        clear_logs();
        send_byte(8'hCC);
        send_byte(8'h12);
        exp_q.push_back('{k: 0, a: 0, d: 32'h12, t: 0});
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rf_wr_en !== 1'b0 || bus.rf_wr_data !== 8'h00
            || bus.rf_addr !== 4'd0 || bus.alu_gate_en !== 1'b0 || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: busy=%b wr=%b data=%h addr=%h gate=%b ferr=%b want all 0",
                     bus.busy, bus.rf_wr_en, bus.rf_wr_data, bus.rf_addr,
                     bus.alu_gate_en, bus.frame_err);
        end
        idle(2);
        RST = 1'b0;
        idle(1);
        b = '{8'hCC, 8'hAB, 8'hCD, 8'h05};
        model_frame(b);
        send_frame(b, 1);
        idle(1);
        resp_pulse();
        idle(1);
        checks++;
        if (fmt(log_q) != fmt(exp_q)) begin
            failures++;
            $display("FAIL reset_mid_events: got '%s' want '%s'", fmt(log_q), fmt(exp_q));
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        logic [7:0] op;
        int kind;
        for (int n = 0; n < 40; n++) begin
            clear_logs();
            kind = $urandom_range(0, 4);
            case (kind)
                0: b = '{8'hAA, 8'($urandom), 8'($urandom)};
                1: b = '{8'hBB, 8'($urandom)};
                2: b = '{8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
                3: b = '{8'hDD, 8'($urandom)};
                default: begin
                    op = 8'($urandom);
                    while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD)
                        op = 8'($urandom);
                    b = '{op};
                end
            endcase
            model_frame(b);
            send_frame(b, 3);
            if (kind >= 1 && kind <= 3) begin
                idle($urandom_range(0, 3));
                resp_pulse();
            end
            idle(1);
            checks++;
            if (fmt(log_q) != fmt(exp_q) || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL random_frame_%0d: got '%s' busy=%b want '%s' busy=0",
                         n, fmt(log_q), bus.busy, fmt(exp_q));
            end
        end
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.par_err   = 1'b0;
        bus.stp_err   = 1'b0;
        bus.resp_done = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_alu();
        test_err_abort();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
